// File: rtl/vote_pkg.sv
// Shared types and encodings for the vote session controller.
package vote_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StVoting,
        StTally,
        StResult
    } state_e;

    // One-hot verdict encodings, bit order matches result[3:1].
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_FAIL = 3'b100;
    localparam logic [2:0] RES_TIE  = 3'b010;
    localparam logic [2:0] RES_PASS = 3'b001;

    localparam int unsigned NumVoters = 4;

    // Number of set bits in a four-voter yes vector.
    function automatic logic [2:0] yes_count(logic [NumVoters-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NumVoters; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/vote_session_ctrl_if.sv
// Session control / ballot / verdict signal bundle for vote_session_ctrl.
interface vote_session_ctrl_if;

    logic       start;
    logic       close;
    logic [3:0] vote_valid;
    logic [3:0] vote_yes;
    logic       busy;
    logic [3:0] voted;
    logic [3:1] result;
    logic       result_valid;
    logic       timed_out;

    modport master (
        output start, close, vote_valid, vote_yes,
        input  busy, voted, result, result_valid, timed_out
    );

    modport slave (
        input  start, close, vote_valid, vote_yes,
        output busy, voted, result, result_valid, timed_out
    );

endinterface

// File: rtl/vote_classifier.sv
// Combinational verdict classifier: 0-1 yes = fail, 2 = tie, 3-4 = pass.
module vote_classifier
    import vote_pkg::*;
(
    input  logic [3:0] yes,
    output logic [2:0] result
);

    // Map the yes count onto the one-hot verdict.
    always_comb begin
        result = RES_NONE;
        case (yes_count(yes))
            3'd0, 3'd1: result = RES_FAIL;
            3'd2:       result = RES_TIE;
            default:    result = RES_PASS;
        endcase
    end

endmodule

// File: rtl/vote_session_ctrl.sv
// Four-voter ballot session controller: IDLE -> VOTING -> TALLY -> RESULT.
// Optional voting-window timeout is enabled by defining VOTE_TIMEOUT_EN.
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                clk,
    input logic                rst,
    vote_session_ctrl_if.slave bus
);

    state_e     state_q, state_d;
    logic [3:0] voted_q, voted_d;
    logic [3:0] ballot_q, ballot_d;
    logic [2:0] result_q, result_d;
    logic       result_valid_q, result_valid_d;
    logic       timed_out_q, timed_out_d;

    logic [3:0] accept;
    logic [2:0] verdict;
    logic       session_open;
    logic       timeout_hit;

    // A new session may only be opened from IDLE or RESULT.
    assign session_open = bus.start && (state_q == StIdle || state_q == StResult);
    assign accept       = bus.vote_valid & ~voted_q;

`ifdef VOTE_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    assign timeout_hit = (state_q == StVoting) && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    // Window counter: cleared on session entry, counts every VOTING cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (session_open) begin
            cnt_d = '0;
        end else if (state_q == StVoting) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Window counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cycles;

    assign timeout_hit           = 1'b0;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    // Unvoted ballots stay 0, so they already count as no.
    vote_classifier u_classifier (
        .yes    (ballot_q),
        .result (verdict)
    );

    // Next-state and datapath update for the session FSM.
    always_comb begin
        state_d        = state_q;
        voted_d        = voted_q;
        ballot_d       = ballot_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        timed_out_d    = timed_out_q;

        unique case (state_q)
            StIdle, StResult: begin
                if (session_open) begin
                    state_d        = StVoting;
                    voted_d        = '0;
                    ballot_d       = '0;
                    result_d       = RES_NONE;
                    result_valid_d = 1'b0;
                    timed_out_d    = 1'b0;
                end
            end
            StVoting: begin
                // Ballots in the closing cycle are still taken.
                voted_d  = voted_q | accept;
                ballot_d = (ballot_q & ~accept) | (bus.vote_yes & accept);
                if ((&voted_d) || bus.close) begin
                    state_d = StTally;
                end else if (timeout_hit) begin
                    state_d     = StTally;
                    timed_out_d = 1'b1;
                end
            end
            StTally: begin
                state_d        = StResult;
                result_d       = verdict;
                result_valid_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Session state registers; reset abandons any session without a verdict.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            voted_q        <= '0;
            ballot_q       <= '0;
            result_q       <= RES_NONE;
            result_valid_q <= 1'b0;
            timed_out_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            voted_q        <= voted_d;
            ballot_q       <= ballot_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timed_out_q    <= timed_out_d;
        end
    end

    assign bus.busy         = (state_q == StVoting) || (state_q == StTally);
    assign bus.voted        = voted_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.timed_out    = timed_out_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Scoreboard bench for vote_session_ctrl: stimulus pushes expected verdicts,
// a negedge monitor pops and compares on each rising result_valid.
module tb_vote_session_ctrl;

    typedef struct packed {
        logic [2:0] res;
        logic [3:0] voted;
        logic       to;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    logic rv_prev = 1'b0;

    vote_session_ctrl_if dut_if ();

    vote_session_ctrl #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input logic [2:0] r, input logic [3:0] v, input logic t);
        exp_t e;
        e.res   = r;
        e.voted = v;
        e.to    = t;
        sb_q.push_back(e);
    endtask

    task automatic vote(input logic [3:0] vv, input logic [3:0] vy, input logic cl);
        dut_if.vote_valid = vv;
        dut_if.vote_yes   = vy;
        dut_if.close      = cl;
        tick();
        dut_if.vote_valid = 4'b0000;
        dut_if.vote_yes   = 4'b0000;
        dut_if.close      = 1'b0;
    endtask

    task automatic pulse_start();
        dut_if.start = 1'b1;
        tick();
        dut_if.start = 1'b0;
    endtask

    // Bounded wait for the verdict, then one more edge so the monitor samples it.
    task automatic wait_result(input string name);
        int k;
        k = 0;
        while (!dut_if.result_valid && k < 40) begin
            tick();
            k++;
        end
        check(name, {31'd0, dut_if.result_valid}, 32'd1);
        tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, dut_if.busy}, 32'd0);
        check({tag, "_voted"}, {28'd0, dut_if.voted}, 32'd0);
        check({tag, "_result"}, {29'd0, dut_if.result}, 32'd0);
        check({tag, "_rv"}, {31'd0, dut_if.result_valid}, 32'd0);
        check({tag, "_to"}, {31'd0, dut_if.timed_out}, 32'd0);
    endtask

    // Monitor: compare each new verdict against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && dut_if.result_valid && !rv_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_verdict", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_result", {29'd0, dut_if.result}, {29'd0, e.res});
                check("sb_voted", {28'd0, dut_if.voted}, {28'd0, e.voted});
                check("sb_timed_out", {31'd0, dut_if.timed_out}, {31'd0, e.to});
            end
        end
        rv_prev <= dut_if.result_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        dut_if.start      = 1'b0;
        dut_if.close      = 1'b0;
        dut_if.vote_valid = 4'b0000;
        dut_if.vote_yes   = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        check_idle_outputs("reset");

        // All four in one cycle, 3 yes -> pass after one TALLY cycle.
        expect_result(3'b001, 4'b1111, 1'b0);
        pulse_start();
        check("voting_busy", {31'd0, dut_if.busy}, 32'd1);
        vote(4'b1111, 4'b1011, 1'b0);
        check("tally_busy", {31'd0, dut_if.busy}, 32'd1);
        check("tally_rv_low", {31'd0, dut_if.result_valid}, 32'd0);
        tick();
        check("latency_rv", {31'd0, dut_if.result_valid}, 32'd1);
        check("result_busy", {31'd0, dut_if.busy}, 32'd0);
        tick();

        // Separate-cycle votes with an ignored re-vote -> tie.
        expect_result(3'b010, 4'b1111, 1'b0);
        pulse_start();
        check("reentry_rv", {31'd0, dut_if.result_valid}, 32'd0);
        check("reentry_voted", {28'd0, dut_if.voted}, 32'd0);
        vote(4'b0001, 4'b0001, 1'b0);
        vote(4'b0100, 4'b0100, 1'b0);
        vote(4'b0010, 4'b0000, 1'b0);
        vote(4'b0001, 4'b0000, 1'b0);
        check("revote_voted", {28'd0, dut_if.voted}, 32'h7);
        check("revote_busy", {31'd0, dut_if.busy}, 32'd1);
        vote(4'b1000, 4'b0000, 1'b0);
        wait_result("tie_wait");

        // Single yes then close -> fail with only voter 1 marked.
        expect_result(3'b100, 4'b0010, 1'b0);
        pulse_start();
        vote(4'b0010, 4'b0010, 1'b0);
        vote(4'b0000, 4'b0000, 1'b1);
        wait_result("close_wait");
        // close outside VOTING is ignored.
        vote(4'b0000, 4'b0000, 1'b1);
        check("close_in_result", {31'd0, dut_if.result_valid}, 32'd1);

        // Ballot in the close cycle is accepted.
        expect_result(3'b100, 4'b0001, 1'b0);
        pulse_start();
        vote(4'b0001, 4'b0001, 1'b1);
        check("close_vote_voted", {28'd0, dut_if.voted}, 32'h1);
        wait_result("close_vote_wait");

        expect_result(3'b001, 4'b0111, 1'b0);
        pulse_start();
        vote(4'b0100, 4'b0100, 1'b0);
        vote(4'b0011, 4'b0011, 1'b1);
        wait_result("close_pass_wait");

        // start during VOTING must not restart the session.
        expect_result(3'b100, 4'b1111, 1'b0);
        pulse_start();
        vote(4'b0001, 4'b0001, 1'b0);
        pulse_start();
        check("start_ignored_voted", {28'd0, dut_if.voted}, 32'h1);
        vote(4'b1110, 4'b0000, 1'b0);
        wait_result("restart_ignored_wait");

        // Mid-session reset abandons with no verdict; rst beats start.
        pulse_start();
        vote(4'b0101, 4'b0101, 1'b0);
        check("pre_reset_voted", {28'd0, dut_if.voted}, 32'h5);
        rst          = 1'b1;
        dut_if.start = 1'b1;
        tick();
        rst          = 1'b0;
        dut_if.start = 1'b0;
        check_idle_outputs("midrst");
        tick();
        check("idle_stays", {31'd0, dut_if.busy}, 32'd0);

        expect_result(3'b001, 4'b1111, 1'b0);
        pulse_start();
        vote(4'b1111, 4'b0111, 1'b0);
        wait_result("post_reset_wait");

`ifdef VOTE_TIMEOUT_EN
        // Window expiry: TALLY 16 cycles after VOTING entry.
        expect_result(3'b100, 4'b1000, 1'b1);
        pulse_start();
        vote(4'b1000, 4'b1000, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        check("timeout_tally_busy", {31'd0, dut_if.busy}, 32'd1);
        check("timeout_tally_rv", {31'd0, dut_if.result_valid}, 32'd0);
        check("timeout_flag", {31'd0, dut_if.timed_out}, 32'd1);
        tick();
        check("timeout_rv", {31'd0, dut_if.result_valid}, 32'd1);
        tick();
`else
        // Without the timeout option VOTING waits indefinitely.
        expect_result(3'b100, 4'b0000, 1'b0);
        pulse_start();
        for (int i = 0; i < 24; i++) tick();
        check("no_timeout_busy", {31'd0, dut_if.busy}, 32'd1);
        check("no_timeout_flag", {31'd0, dut_if.timed_out}, 32'd0);
        vote(4'b0000, 4'b0000, 1'b1);
        wait_result("no_timeout_wait");
`endif

        tick();
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
